slip_frame_rx: RTL and testbench

SLIP_FRAME_RX -- requirements
Module: slip_frame_rx

---
 rtl/slip_frame_rx.sv | 173 +++++++++++++++++
 tb/tb_slip_frame_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slip_frame_rx.sv
// SLIP frame receiver: decodes a byte stream into a single-frame payload buffer
// that is held for a consumer until acknowledged.
module slip_frame_rx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_rx_dv,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_frame_ack,
  input  logic [LEN_W-1:0] i_rd_addr,
  output logic [7:0]       o_rd_byte,
  output logic             o_frame_valid,
  output logic [LEN_W-1:0] o_frame_len,
  output logic             o_frame_err,
  output logic             o_drop
);

  localparam logic [2:0] ST_SYNC    = 3'd0;
  localparam logic [2:0] ST_RECV    = 3'd1;
  localparam logic [2:0] ST_ESC     = 3'd2;
  localparam logic [2:0] ST_DISCARD = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam int DEPTH = 1 << LEN_W;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             valid_q, valid_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;
  logic             hold_drop_q, hold_drop_d;
  logic [7:0]       rd_byte_q, rd_byte_d;

  logic             store_req;
  logic [7:0]       store_data;
  logic             wr_en;

  // Sized to the full address range so any i_rd_addr indexes a real entry.
  logic [7:0] buf_mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    valid_d     = valid_q;
    flen_d      = flen_q;
    err_d       = 1'b0;
    drop_d      = 1'b0;
    hold_drop_d = hold_drop_q;
    store_req   = 1'b0;
    store_data  = i_rx_byte;
    wr_en       = 1'b0;
    rd_byte_d   = buf_mem[i_rd_addr];

    case (state_q)
      ST_SYNC: begin
        if (i_rx_dv && i_rx_byte == SLIP_END) begin
          state_d = ST_RECV;
          len_d   = '0;
        end
      end
      ST_RECV: begin
        if (i_rx_dv) begin
          if (i_rx_byte == SLIP_END) begin
            if (len_q != '0) begin
              flen_d  = len_q;
              valid_d = 1'b1;
              state_d = ST_HOLD;
            end
          end else if (i_rx_byte == SLIP_ESC) begin
            state_d = ST_ESC;
          end else begin
            store_req = 1'b1;
          end
        end
      end
      ST_ESC: begin
        if (i_rx_dv) begin
          if (i_rx_byte == SLIP_ESC_END) begin
            store_req  = 1'b1;
            store_data = SLIP_END;
          end else if (i_rx_byte == SLIP_ESC_ESC) begin
            store_req  = 1'b1;
            store_data = SLIP_ESC;
          end else if (i_rx_byte == SLIP_END) begin
            err_d   = 1'b1;
            len_d   = '0;
            state_d = ST_RECV;
          end else begin
            err_d   = 1'b1;
            len_d   = '0;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (i_rx_dv && i_rx_byte == SLIP_END) begin
          state_d = ST_RECV;
          len_d   = '0;
        end
      end
      ST_HOLD: begin
        if (i_rx_dv) begin
          drop_d      = 1'b1;
          hold_drop_d = 1'b1;
        end
        // Any byte lost during the hold means we may be mid-frame, so resync.
        if (i_frame_ack) begin
          valid_d     = 1'b0;
          len_d       = '0;
          hold_drop_d = 1'b0;
          state_d     = (hold_drop_q || i_rx_dv) ? ST_SYNC : ST_RECV;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (store_req) begin
      if (len_q == MAX_LEN_V) begin
        err_d   = 1'b1;
        len_d   = '0;
        state_d = ST_DISCARD;
      end else begin
        wr_en   = 1'b1;
        len_d   = len_q + 1'b1;
        state_d = ST_RECV;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      len_q       <= '0;
      valid_q     <= 1'b0;
      flen_q      <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      hold_drop_q <= 1'b0;
      rd_byte_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      flen_q      <= flen_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      hold_drop_q <= hold_drop_d;
      rd_byte_q   <= rd_byte_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[len_q] <= store_data;
    end
  end

  assign o_rd_byte     = rd_byte_q;
  assign o_frame_valid = valid_q;
  assign o_frame_len   = flen_q;
  assign o_frame_err   = err_q;
  assign o_drop        = drop_q;

endmodule

// File: tb/tb_slip_frame_rx.sv
// Self-checking bench for slip_frame_rx: a queue-based frame model predicts the
// outputs every cycle, and directed sequences pin hand-computed results.
module tb_slip_frame_rx;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_rx_dv;
  logic [7:0]       i_rx_byte;
  logic             i_frame_ack;
  logic [LEN_W-1:0] i_rd_addr;
  logic [7:0]       o_rd_byte;
  logic             o_frame_valid;
  logic [LEN_W-1:0] o_frame_len;
  logic             o_frame_err;
  logic             o_drop;

  slip_frame_rx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx_dv      (i_rx_dv),
    .i_rx_byte    (i_rx_byte),
    .i_frame_ack  (i_frame_ack),
    .i_rd_addr    (i_rd_addr),
    .o_rd_byte    (o_rd_byte),
    .o_frame_valid(o_frame_valid),
    .o_frame_len  (o_frame_len),
    .o_frame_err  (o_frame_err),
    .o_drop       (o_drop)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0, drop_seen = 0, frames_seen = 0;
  int snap_err, snap_drop, snap_frames;

  // Model: frame bytes in a queue, plus the receiver's protocol situation as flags.
  bit         mdl_synced, mdl_esc, mdl_discard, mdl_holding, mdl_dropped;
  logic [7:0] cur[$];
  logic [7:0] held[$];
  logic [7:0] seq[$];
  logic       exp_valid, exp_err, exp_drop;
  logic [3:0] exp_len;
  logic [3:0] chk_addr;
  logic       prev_valid;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mdl_synced = 0; mdl_esc = 0; mdl_discard = 0; mdl_holding = 0; mdl_dropped = 0;
    cur.delete(); held.delete();
    exp_valid = 0; exp_err = 0; exp_drop = 0; exp_len = 0; chk_addr = 0;
  endtask

  task automatic modelStore(input logic [7:0] x);
    if (cur.size() == MAX_LEN) begin
      exp_err = 1; cur.delete(); mdl_discard = 1;
    end else begin
      cur.push_back(x);
    end
  endtask

  task automatic modelStep(input logic dv, input logic [7:0] b, input logic ack,
                           input logic [3:0] addr);
    exp_err  = 0;
    exp_drop = 0;
    chk_addr = addr;
    if (mdl_holding) begin
      if (dv) begin exp_drop = 1; mdl_dropped = 1; end
      if (ack) begin
        mdl_holding = 0; exp_valid = 0;
        mdl_synced = !mdl_dropped; mdl_dropped = 0;
        cur.delete(); mdl_esc = 0; mdl_discard = 0;
      end
    end else if (dv) begin
      if (!mdl_synced) begin
        if (b == 8'hC0) begin mdl_synced = 1; cur.delete(); end
      end else if (mdl_discard) begin
        if (b == 8'hC0) begin mdl_discard = 0; cur.delete(); end
      end else if (mdl_esc) begin
        mdl_esc = 0;
        if (b == 8'hDC) modelStore(8'hC0);
        else if (b == 8'hDD) modelStore(8'hDB);
        else if (b == 8'hC0) begin exp_err = 1; cur.delete(); end
        else begin exp_err = 1; cur.delete(); mdl_discard = 1; end
      end else if (b == 8'hC0) begin
        if (cur.size() > 0) begin
          held = cur; exp_len = 4'(cur.size()); exp_valid = 1;
          mdl_holding = 1; cur.delete();
        end
      end else if (b == 8'hDB) begin
        mdl_esc = 1;
      end else begin
        modelStore(b);
      end
    end
  endtask

  // Per-cycle comparison against the model, plus pulse/frame tallies.
  initial begin
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 0;
      end else begin
        checkOutput("frame_valid", o_frame_valid, exp_valid);
        checkOutput("frame_err", o_frame_err, exp_err);
        checkOutput("drop", o_drop, exp_drop);
        if (exp_valid) begin
          checkOutput("frame_len", o_frame_len, exp_len);
          if (chk_addr < exp_len) checkOutput("rd_byte", o_rd_byte, held[chk_addr]);
        end
        if (o_frame_err) err_seen++;
        if (o_drop) drop_seen++;
        if (o_frame_valid && !prev_valid) frames_seen++;
        prev_valid = o_frame_valid;
      end
    end
  end

  task automatic applyStimulus(input logic dv, input logic [7:0] b, input logic ack);
    i_rx_dv = dv; i_rx_byte = b; i_frame_ack = ack;
    @(posedge clk);
    modelStep(dv, b, ack, i_rd_addr);
    #1;
    i_rx_dv = 0; i_frame_ack = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0);
  endtask

  task automatic sendSeq();
    foreach (seq[i]) applyStimulus(1, seq[i], 0);
  endtask

  task automatic checkFrame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit do_ack);
    logic [7:0] e[3];
    e[0] = b0; e[1] = b1; e[2] = b2;
    for (int i = 0; i < 4; i++) begin
      if (o_frame_valid) break;
      idle(1);
    end
    if (!o_frame_valid) begin
      checkOutput("frame_timeout", 0, 1);
      return;
    end
    checkOutput("len_literal", o_frame_len, n);
    for (int k = 0; k < n; k++) begin
      i_rd_addr = 4'(k);
      applyStimulus(0, 8'h00, 0);
      checkOutput("rd_literal", o_rd_byte, e[k]);
    end
    i_rd_addr = 0;
    if (do_ack) begin
      applyStimulus(0, 8'h00, 1);
      idle(1);
    end
  endtask

  task automatic snapshot();
    snap_err = err_seen; snap_drop = drop_seen; snap_frames = frames_seen;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 0; i_rx_dv = 0; i_rx_byte = 0; i_frame_ack = 0; i_rd_addr = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", o_frame_valid, 0);
    checkOutput("rst_len", o_frame_len, 0);
    checkOutput("rst_err", o_frame_err, 0);
    checkOutput("rst_drop", o_drop, 0);
    checkOutput("rst_rd_byte", o_rd_byte, 0);
    reset = 1;
    idle(2);

    // Basic frame, then a headerless frame proves the ack returned to RECV.
    seq = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0}; sendSeq();
    checkFrame(3, 8'h01, 8'h02, 8'h03, 1);
    seq = '{8'h07, 8'hC0}; sendSeq();
    checkFrame(1, 8'h07, 8'h00, 8'h00, 1);

    seq = '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h7E, 8'hC0}; sendSeq();
    checkFrame(3, 8'hC0, 8'hDB, 8'h7E, 1);

    snapshot();
    seq = '{8'hC0, 8'hC0, 8'hC0}; sendSeq(); idle(2);
    checkOutput("empty_frames", frames_seen, snap_frames);
    checkOutput("empty_errs", err_seen, snap_err);

    // Overflow on the ninth payload byte.
    snapshot();
    seq = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'hC0};
    sendSeq(); idle(2);
    checkOutput("ovf_errs", err_seen, snap_err + 1);
    checkOutput("ovf_frames", frames_seen, snap_frames);
    seq = '{8'hC0, 8'hAA, 8'hC0}; sendSeq();
    checkFrame(1, 8'hAA, 8'h00, 8'h00, 1);

    snapshot();
    seq = '{8'hC0, 8'h11, 8'hDB, 8'h55, 8'h22, 8'hC0}; sendSeq(); idle(2);
    checkOutput("badesc_errs", err_seen, snap_err + 1);
    checkOutput("badesc_frames", frames_seen, snap_frames);
    snapshot();
    seq = '{8'hC0, 8'h11, 8'hDB, 8'hC0, 8'h33, 8'hC0}; sendSeq();
    checkFrame(1, 8'h33, 8'h00, 8'h00, 0);
    checkOutput("escend_errs", err_seen, snap_err + 1);
    applyStimulus(0, 8'h00, 1); idle(1);

    // Drops while held force a resync after ack.
    seq = '{8'hC0, 8'h66, 8'hC0}; sendSeq();
    checkFrame(1, 8'h66, 8'h00, 8'h00, 0);
    snapshot();
    seq = '{8'h44, 8'h45}; sendSeq(); idle(1);
    checkOutput("hold_drops", drop_seen, snap_drop + 2);
    applyStimulus(0, 8'h00, 0);
    checkOutput("hold_buf", o_rd_byte, 8'h66);
    applyStimulus(0, 8'h00, 1); idle(1);
    snapshot();
    seq = '{8'h99, 8'hC0}; sendSeq(); idle(2);
    checkOutput("resync_frames", frames_seen, snap_frames);
    seq = '{8'hC0, 8'h99, 8'hC0}; sendSeq();
    checkFrame(1, 8'h99, 8'h00, 8'h00, 1);

    // Byte and ack in the same cycle.
    seq = '{8'h12, 8'hC0}; sendSeq();
    checkFrame(1, 8'h12, 8'h00, 8'h00, 0);
    snapshot();
    applyStimulus(1, 8'h34, 1); idle(1);
    checkOutput("ackdrop_drops", drop_seen, snap_drop + 1);
    seq = '{8'h99, 8'hC0}; sendSeq(); idle(2);
    checkOutput("ackdrop_frames", frames_seen, snap_frames);
    seq = '{8'hC0, 8'h99, 8'hC0}; sendSeq();
    checkFrame(1, 8'h99, 8'h00, 8'h00, 1);

    // Asynchronous reset while a frame is held.
    seq = '{8'h77, 8'hC0}; sendSeq();
    checkFrame(1, 8'h77, 8'h00, 8'h00, 0);
    snapshot();
    #1 reset = 0; modelReset();
    #1;
    checkOutput("arst_hold_valid", o_frame_valid, 0);
    checkOutput("arst_hold_len", o_frame_len, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    idle(1);

    // Asynchronous reset mid-frame.
    seq = '{8'hC0, 8'h01, 8'h02}; sendSeq();
    #1 reset = 0; modelReset();
    #1;
    checkOutput("arst_valid", o_frame_valid, 0);
    checkOutput("arst_err", o_frame_err, 0);
    checkOutput("arst_rd_byte", o_rd_byte, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    seq = '{8'h01, 8'hC0}; sendSeq(); idle(2);
    checkOutput("arst_no_frame", frames_seen, snap_frames);
    checkOutput("arst_no_err", err_seen, snap_err);
    seq = '{8'hC0, 8'h05, 8'hC0}; sendSeq();
    checkFrame(1, 8'h05, 8'h00, 8'h00, 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
